// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer. It streams operand word pairs, least-significant
// word first, through one 32-bit carry-select adder and chains the carry in a flop.
module mp_add_seq #(
  parameter int DW    = 32,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  input  logic             cin_ext,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_sum,
  output logic             out_last,
  output logic             done,
  output logic             flag_out
);

  // Handshake: a word moves on any rising edge where valid and ready are both high.
  // The producer holds its word until then. Ready never depends on valid.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int HW = DW / 2;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q;
  logic             op_q;
  logic             carry_q;
  logic [DW-1:0]    sum_q;
  logic             valid_q, last_q, done_q, flag_q;

  logic             in_hs, out_hs, cmd_ok;
  logic [DW-1:0]    add_a, add_b, add_sum;
  logic             add_cout;
  logic [HW:0]      lo_sum, hi_sum0, hi_sum1;

  assign cmd_ok   = (state_q == IDLE) && start && (len != '0);
  assign in_ready = (state_q == RUN) && (cnt_q != '0) && (!valid_q || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = valid_q && out_ready;

  // Subtraction adds the inverted B operand. The carry flop was preloaded with 1 at start.
  assign add_a = in_a;
  assign add_b = in_b ^ {DW{op_q}};

  // Carry-select: compute the upper half for both carry-ins, then pick one with the lower carry.
  assign lo_sum   = {1'b0, add_a[HW-1:0]} + {1'b0, add_b[HW-1:0]} + {{HW{1'b0}}, carry_q};
  assign hi_sum0  = {1'b0, add_a[DW-1:HW]} + {1'b0, add_b[DW-1:HW]};
  assign hi_sum1  = hi_sum0 + {{HW{1'b0}}, 1'b1};
  assign add_sum  = {(lo_sum[HW] ? hi_sum1[HW-1:0] : hi_sum0[HW-1:0]), lo_sum[HW-1:0]};
  assign add_cout = lo_sum[HW] ? hi_sum1[HW] : hi_sum0[HW];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_ok) state_d = RUN;
      RUN:     if (out_hs && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == RUN) && out_hs && last_q;
      if (cmd_ok) begin
        cnt_q   <= len;
        op_q    <= sub;
        carry_q <= sub ? 1'b1 : cin_ext;
        flag_q  <= 1'b0;
      end
      if (in_hs) begin
        sum_q   <= add_sum;
        carry_q <= add_cout;
        valid_q <= 1'b1;
        last_q  <= (cnt_q == LEN_W'(1));
        cnt_q   <= cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) flag_q <= op_q ? ~add_cout : add_cout;
      end else if (out_hs) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign flag_out  = flag_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq. It replays a table of multi-word add/sub vectors and then
// runs hand-written illegal-command and async-reset sequences.
module tb_mp_add_seq;
  localparam int DW    = 32;
  localparam int LEN_W = 4;

  logic             clk, rst_n;
  logic             start, sub, cin_ext;
  logic [LEN_W-1:0] len;
  logic             busy, in_valid, in_ready, out_valid, out_ready, out_last, done, flag_out;
  logic [DW-1:0]    in_a, in_b, out_sum;

  mp_add_seq #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sub(sub), .cin_ext(cin_ext),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
    .done(done), .flag_out(flag_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          op;
    bit          cin;
    logic [31:0] a[4];
    logic [31:0] b[4];
    logic [31:0] e[4];
    bit          flag;
    int          stall;
    bit          mid_start;
  } vec_t;

  vec_t          vecs[7];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver + scoreboard for one transaction; returns at the negedge after the final handshake
  task automatic run_vec(input int id, input vec_t v);
    int wi = 0, oi = 0, cyc = 0, stalled = 0, done_seen = 0;
    bit was_stall = 0;
    logic [31:0] held = '0;
    string tag;
    tag = $sformatf("v%0d", id);
    exp_q.delete();
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.e[i]);
    @(negedge clk);
    start = 1'b1; len = LEN_W'(v.n); sub = v.op; cin_ext = v.cin;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " flag_cleared"}, 32'(flag_out), 32'd0);
    while (oi < v.n && cyc < 100) begin
      start = v.mid_start && (cyc == 2);
      if (start) begin len = 4'd7; sub = 1'b1; end
      out_ready = !(v.stall > 0 && out_valid && stalled < v.stall);
      in_valid  = (wi < v.n);
      in_a      = (wi < v.n) ? v.a[wi] : 32'hDEAD_BEEF;
      in_b      = (wi < v.n) ? v.b[wi] : 32'hDEAD_BEEF;
      #1;
      if (done) done_seen++;
      if (!out_ready) begin
        stalled++;
        check({tag, " in_ready_stall"}, 32'(in_ready), 32'd0);
        if (was_stall) check({tag, " sum_held"}, out_sum, held);
        held = out_sum;
        was_stall = 1;
      end else begin
        was_stall = 0;
      end
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL %s extra_word: got %h, expected none", tag, out_sum);
        end else begin
          check({tag, $sformatf(" sum[%0d]", oi)}, out_sum, exp_q.pop_front());
        end
        check({tag, $sformatf(" last[%0d]", oi)}, 32'(out_last), 32'(oi == v.n - 1));
        oi++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check({tag, " cycles"}, 32'(cyc), 32'(v.n + 1 + v.stall));
    check({tag, " early_done"}, 32'(done_seen), 32'd0);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_off"}, 32'(busy), 32'd0);
    check({tag, " flag"}, 32'(flag_out), 32'(v.flag));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " flag_hold"}, 32'(flag_out), 32'(v.flag));
    check({tag, " out_valid_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{n:2, op:0, cin:0, a:'{32'hFFFFFFFF, 0, 0, 0}, b:'{32'h1, 0, 0, 0},
                e:'{32'h0, 32'h1, 0, 0}, flag:0, stall:0, mid_start:0};
    vecs[1] = '{n:1, op:1, cin:0, a:'{32'h5, 0, 0, 0}, b:'{32'h7, 0, 0, 0},
                e:'{32'hFFFFFFFE, 0, 0, 0}, flag:1, stall:0, mid_start:0};
    vecs[2] = '{n:3, op:0, cin:1, a:'{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0},
                b:'{0, 0, 0, 0}, e:'{0, 0, 0, 0}, flag:1, stall:0, mid_start:0};
    vecs[3] = '{n:4, op:0, cin:0, a:'{32'h1, 32'h2, 32'h3, 32'h4},
                b:'{32'h10, 32'h20, 32'h30, 32'h40}, e:'{32'h11, 32'h22, 32'h33, 32'h44},
                flag:0, stall:3, mid_start:0};
    vecs[4] = '{n:2, op:1, cin:0, a:'{32'h0, 32'h5, 0, 0}, b:'{32'h1, 32'h2, 0, 0},
                e:'{32'hFFFFFFFF, 32'h2, 0, 0}, flag:0, stall:0, mid_start:0};
    vecs[5] = '{n:2, op:0, cin:0, a:'{32'h80000000, 32'h7FFFFFFF, 0, 0},
                b:'{32'h80000000, 32'h0, 0, 0}, e:'{32'h0, 32'h80000000, 0, 0},
                flag:0, stall:0, mid_start:1};
    vecs[6] = '{n:2, op:0, cin:0, a:'{32'h0000FFFF, 32'hFFFF0000, 0, 0},
                b:'{32'h00000001, 32'h00010000, 0, 0}, e:'{32'h00010000, 32'h0, 0, 0},
                flag:1, stall:0, mid_start:0};

    rst_n = 1'b0; start = 1'b0; len = '0; sub = 1'b0; cin_ext = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_sum", out_sum, 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst flag", 32'(flag_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start with len=0 in IDLE must be ignored
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0 busy", 32'(busy), 32'd0);
    check("len0 in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("len0 done", 32'(done), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // async reset after 2 of 5 words
    @(negedge clk);
    start = 1'b1; len = 4'd5; sub = 1'b0; cin_ext = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h0;
    @(negedge clk);
    in_a = 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst out_valid", 32'(out_valid), 32'd1);
    check("pre_rst out_sum", out_sum, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst in_ready", 32'(in_ready), 32'd0);
    check("mid_rst out_valid", 32'(out_valid), 32'd0);
    check("mid_rst out_last", 32'(out_last), 32'd0);
    check("mid_rst out_sum", out_sum, 32'd0);
    check("mid_rst flag", 32'(flag_out), 32'd0);
    @(negedge clk);
    check("mid_rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst done", 32'(done), 32'd0);
    check("post_rst busy", 32'(busy), 32'd0);
    run_vec(7, '{n:1, op:0, cin:0, a:'{32'h1, 0, 0, 0}, b:'{32'h2, 0, 0, 0},
                e:'{32'h3, 0, 0, 0}, flag:0, stall:0, mid_start:0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision add/subtract sequencer built around one 32-bit carry-select adder instance, which it drives one word per cycle. A start command sets the word count and operation. Operand word pairs stream in least-significant word first, and result words stream out through a registered valid/ready port. Carry or borrow is chained between words in a flop. The block lets 64- to 480-bit arithmetic reuse the single 32-bit adder instead of a wide combinational adder.

Parameters:
DW, 32, datapath word width; fixed to the adder width and not changed.
LEN_W, 4, width of the word-count field; maximum operand length is 2^LEN_W-1 words (15).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  command strobe; sampled only in IDLE.
len  input  LEN_W  operand length in words; sampled with start.
sub  input  1  operation; 0 = A+B, 1 = A-B. Sampled with start.
cin_ext  input  1  initial carry for add; ignored when sub=1.
busy  output  1  high from accepted start until the final result word handshakes.
in_valid  input  1  operand word pair valid.
in_ready  output  1  operand word pair accepted when in_valid and in_ready are both high.
in_a  input  DW  operand A word, LSW first.
in_b  input  DW  operand B word, LSW first.
out_valid  output  1  result word valid.
out_ready  input  1  downstream accepts the result word.
out_sum  output  DW  result word.
out_last  output  1  marks the most-significant result word.
done  output  1  one-cycle pulse after the final result word handshakes.
flag_out  output  1  final carry for add, final borrow for sub; valid from done onward.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, in_ready, out_valid, out_last, done and flag_out all 0.
  - out_sum=0; internal carry flop=0; word counter=0.
- States:
  - IDLE -> RUN on start=1 with len!=0.
    - Latch len into the counter and sub into op_r.
    - Load carry = sub ? 1 : cin_ext.
    - busy=1 from the next cycle.
  - start with len=0 is ignored: no state change, no done pulse.
  - start is ignored outside IDLE.
  - RUN -> IDLE on the output handshake of the word with out_last=1.
    - done=1 for exactly that following cycle.
    - busy=0 in that same cycle.
- in_ready = (state==RUN) and (counter!=0) and (out_valid==0 or out_ready==1). This is combinational from registered state and out_ready.
- On input handshake, in one cycle:
  - Adder inputs: a=in_a, b=in_b XOR {DW{op_r}}, cin=carry.
  - out_sum <= adder sum; carry <= adder cout; out_valid <= 1.
  - out_last <= (counter==1); counter <= counter-1.
- Latency: a result word is presented the cycle after its operand handshake.
- Throughput: one word per cycle while in_valid and out_ready are both held high.
- Output holding:
  - out_sum and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid drops after a handshake unless a new input is accepted in the same cycle.
- Simultaneous output handshake and input handshake: the register reloads with the new word and out_valid stays 1.
- flag_out:
  - Updated when the last word is accepted: flag_out <= op_r ? ~cout : cout.
  - Held until the next accepted start, which clears it to 0.
- Overflow: carry/borrow beyond the top word is reported only via flag_out. No extra result word is emitted.
- Arithmetic:
  - Words are modulo 2^DW.
  - Subtraction is two's complement via the inverted B operand with initial carry 1.
  - For sub, borrow = NOT carry.
- Reset mid-operation aborts immediately to the reset values. No done pulse is issued.
- Inputs while in_ready=0 are ignored; in_a and in_b need not be stable then.

Test Plan:
1. Add across a word boundary.
   - Stimulus: len=2, sub=0, cin_ext=0, words (A,B) = (0xFFFFFFFF,0x00000001) then (0x00000000,0x00000000).
   - Response: out_sum = 0x00000000 then 0x00000001, out_last on word 2, flag_out=0, done one cycle after word 2 handshakes.
2. Subtract with borrow.
   - Stimulus: len=1, sub=1, A=0x00000005, B=0x00000007.
   - Response: out_sum=0xFFFFFFFE, flag_out=1 (borrow), busy drops with done.
3. Carry out of the top word.
   - Stimulus: len=3, sub=0, all A words=0xFFFFFFFF, all B words=0, cin_ext=1.
   - Response: three result words 0x00000000, flag_out=1.
4. Backpressure.
   - Stimulus: len=4 streaming, out_ready held low for 3 cycles after the first result.
   - Response: in_ready=0 during the stall, out_sum held stable, no words lost or duplicated, full throughput once out_ready returns high.
5. Illegal commands.
   - Stimulus: start with len=0 in IDLE; then start asserted during RUN.
   - Response: no state change in either case, the running transfer completes unchanged, exactly one done pulse.
6. Async reset mid-operation.
   - Stimulus: rst_n low after 2 of 5 words.
   - Response: all outputs go to their reset values immediately, no done pulse; a subsequent len=1 add of 0x00000001 + 0x00000002 returns 0x00000003.
